// File: rtl/wb_pipe_stage.sv
// MEM/WB pipeline register with valid/ready handshake, optional skid entry,
// flush, and a write-back forwarding tap for the hazard unit.
module wb_pipe_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] read_data_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [RD_W-1:0]   rd_addr_i,
  input  logic              reg_write_i,
  input  logic              mem_to_reg_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] read_data_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [RD_W-1:0]   rd_addr_o,
  output logic              reg_write_o,
  output logic              mem_to_reg_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic              fwd_hit_o
);

  typedef struct packed {
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [RD_W-1:0]   rd_addr;
    logic              reg_write;
    logic              mem_to_reg;
  } wb_t;

  wb_t  in_e;
  wb_t  m_q;
  logic m_v;
  logic accept;
  logic rel;

  assign in_e = {read_data_i, alu_result_i, rd_addr_i,
                 reg_write_i, mem_to_reg_i};

  assign accept = valid_i & ready_o;
  assign rel    = m_v & ready_i;

  if (SKID != 0) begin : g_skid
    wb_t  s_q;
    logic s_v;

    // ready depends only on the skid flag, never on ready_i
    assign ready_o = ~s_v;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        m_v <= 1'b0;
        s_v <= 1'b0;
      end else if (flush_i) begin
        m_v <= 1'b0;
        s_v <= 1'b0;
      end else if (rel) begin
        if (s_v) begin
          s_v <= 1'b0;
        end else begin
          m_v <= accept;
        end
      end else if (accept) begin
        if (m_v) begin
          s_v <= 1'b1;
        end else begin
          m_v <= 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        m_q <= '0;
      end else if (!flush_i) begin
        if (rel && s_v) begin
          m_q <= s_q;
        end else if (accept && (!m_v || rel)) begin
          m_q <= in_e;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        s_q <= '0;
      end else if (!flush_i && accept && m_v && !rel) begin
        s_q <= in_e;
      end
    end
  end else begin : g_flat
    assign ready_o = ~m_v | ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        m_v <= 1'b0;
      end else if (flush_i) begin
        m_v <= 1'b0;
      end else if (accept) begin
        m_v <= 1'b1;
      end else if (rel) begin
        m_v <= 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        m_q <= '0;
      end else if (!flush_i && accept) begin
        m_q <= in_e;
      end
    end
  end

  assign valid_o      = m_v;
  assign read_data_o  = m_q.read_data;
  assign alu_result_o = m_q.alu_result;
  assign rd_addr_o    = m_q.rd_addr;
  assign mem_to_reg_o = m_q.mem_to_reg;
  // bubbles never write the register file
  assign reg_write_o  = m_q.reg_write & m_v;

  assign fwd_data_o = m_q.mem_to_reg ? m_q.read_data
                                     : m_q.alu_result;
  assign fwd_hit_o  = m_v & reg_write_o & (m_q.rd_addr != '0);

endmodule
